conv_addr_seq: RTL and testbench

CONV_ADDR_SEQ -- requirements
Module: conv_addr_seq

---
 rtl/conv_addr_seq_if.sv | 10 +
 rtl/conv_addr_seq.sv | 152 +++++++++++++++
 tb/tb_conv_addr_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/conv_addr_seq_if.sv
// conv_addr_seq_if: address-pair valid/ready channel between the sequencer and its consumer.
interface conv_addr_seq_if #(parameter int ADDRW = 16);
  logic addr_valid;
  logic addr_ready;
  logic last_mac;
  logic [ADDRW-1:0] addr_x;
  logic [ADDRW-1:0] addr_w;
  modport master(output addr_valid, addr_x, addr_w, last_mac, input addr_ready);
  modport slave(input addr_valid, addr_x, addr_w, last_mac, output addr_ready);
endinterface

// File: rtl/conv_addr_seq.sv
// conv_addr_seq: convolution address sequencer (row-major outputs, row-major kernel taps).
// Defining CONV_SEQ_STRIDE_EN adds a 2-bit stride input latched at start.
module conv_addr_seq #(
  parameter int DIMW  = 8,
  parameter int ADDRW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DIMW-1:0] n_dim,
  input  logic [DIMW-1:0] m_dim,
`ifdef CONV_SEQ_STRIDE_EN
  input  logic [1:0]      stride,
`endif
  conv_addr_seq_if.master aif,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int P = DIMW + 2;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q;
  logic [DIMW-1:0] n_q, m_q, i_q, j_q;
  logic [P-1:0] cpos_q, rpos_q;
  logic [ADDRW-1:0] rowst_q, out_q, tap_q, x_q, w_q;
  logic valid_q, last_q, busy_q, done_q, err_q;
  logic [1:0] s, s_in;
  logic legal, hs, j_end, col_last, row_last;
  logic [ADDRW-1:0] n_a, s_a, sn;
`ifdef CONV_SEQ_STRIDE_EN
  logic [1:0] s_q;
  assign s = s_q;
  assign s_in = stride;
`else
  assign s = 2'd1;
  assign s_in = 2'd1;
`endif
  assign legal = (m_dim != '0) && (m_dim <= n_dim) && (s_in != 2'd0);
  assign hs = valid_q && aif.addr_ready;
  assign j_end = j_q == m_q - 1'b1;
  // a next window exists only if it still fits inside the image; leftovers are skipped
  assign col_last = cpos_q + P'(s) + P'(m_q) > P'(n_q);
  assign row_last = rpos_q + P'(s) + P'(m_q) > P'(n_q);
  assign n_a = ADDRW'(n_q);
  assign s_a = ADDRW'(s);
  assign sn = (s[0] ? n_a : '0) + (s[1] ? n_a << 1 : '0);
  assign aif.addr_valid = valid_q;
  assign aif.addr_x = x_q;
  assign aif.addr_w = w_q;
  assign aif.last_mac = last_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q <= '0;
      m_q <= '0;
      i_q <= '0;
      j_q <= '0;
      cpos_q <= '0;
      rpos_q <= '0;
      rowst_q <= '0;
      out_q <= '0;
      tap_q <= '0;
      x_q <= '0;
      w_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef CONV_SEQ_STRIDE_EN
      s_q <= 2'd0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (legal) begin
            n_q <= n_dim;
            m_q <= m_dim;
`ifdef CONV_SEQ_STRIDE_EN
            s_q <= stride;
`endif
            state_q <= RUN;
            busy_q <= 1'b1;
            valid_q <= 1'b1;
            i_q <= '0;
            j_q <= '0;
            cpos_q <= '0;
            rpos_q <= '0;
            rowst_q <= '0;
            out_q <= '0;
            tap_q <= '0;
            x_q <= '0;
            w_q <= '0;
            last_q <= m_dim == DIMW'(1);
          end else begin
            err_q <= 1'b1;
          end
        end
        RUN: if (hs) begin
          if (!last_q) begin
            w_q <= w_q + 1'b1;
            if (j_end) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
              tap_q <= tap_q + n_a;
              x_q <= tap_q + n_a;
              last_q <= 1'b0;
            end else begin
              j_q <= j_q + 1'b1;
              x_q <= x_q + 1'b1;
              last_q <= (i_q == m_q - 1'b1) && (j_q + 1'b1 == m_q - 1'b1);
            end
          end else if (!col_last) begin
            i_q <= '0;
            j_q <= '0;
            w_q <= '0;
            cpos_q <= cpos_q + P'(s);
            out_q <= out_q + s_a;
            tap_q <= out_q + s_a;
            x_q <= out_q + s_a;
            last_q <= m_q == DIMW'(1);
          end else if (!row_last) begin
            i_q <= '0;
            j_q <= '0;
            w_q <= '0;
            cpos_q <= '0;
            rpos_q <= rpos_q + P'(s);
            rowst_q <= rowst_q + sn;
            out_q <= rowst_q + sn;
            tap_q <= rowst_q + sn;
            x_q <= rowst_q + sn;
            last_q <= m_q == DIMW'(1);
          end else begin
            state_q <= FINISH;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            last_q <= 1'b0;
            x_q <= '0;
            w_q <= '0;
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_addr_seq.sv
// tb_conv_addr_seq: directed and randomized passes checked against a nested-loop address model.
module tb_conv_addr_seq;
  localparam int DIMW = 8;
  localparam int ADDRW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [DIMW-1:0] n_dim = '0;
  logic [DIMW-1:0] m_dim = '0;
  logic busy, done, err;
`ifdef CONV_SEQ_STRIDE_EN
  logic [1:0] stride = 2'd1;
`endif
  int errors = 0;
  int checks = 0;
  int exp_x[$];
  int exp_w[$];
  bit exp_l[$];
  conv_addr_seq_if #(.ADDRW(ADDRW)) aif();
  conv_addr_seq #(.DIMW(DIMW), .ADDRW(ADDRW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .n_dim(n_dim),
    .m_dim(m_dim),
`ifdef CONV_SEQ_STRIDE_EN
    .stride(stride),
`endif
    .aif(aif),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic build(input int n, input int m, input int s);
    int r;
    exp_x.delete();
    exp_w.delete();
    exp_l.delete();
    r = (n - m) / s + 1;
    for (int orow = 0; orow < r; orow++)
      for (int ocol = 0; ocol < r; ocol++)
        for (int i = 0; i < m; i++)
          for (int j = 0; j < m; j++) begin
            exp_x.push_back((orow * s + i) * n + ocol * s + j);
            exp_w.push_back(i * m + j);
            exp_l.push_back(i == m - 1 && j == m - 1);
          end
  endtask

  task automatic set_cfg(input int n, input int m, input int s);
    n_dim = DIMW'(n);
    m_dim = DIMW'(m);
`ifdef CONV_SEQ_STRIDE_EN
    stride = 2'(s);
`endif
  endtask

  function automatic logic [63:0] outs();
    return {30'd0, aif.addr_valid, aif.last_mac, aif.addr_w, aif.addr_x};
  endfunction

  // mode: 0 always ready, 1 toggling ready, 2 random ready
  task automatic run_pass(input string tag, input int n, input int m, input int s,
                          input int mode, input int abort_at, input bit mid_start);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit hold = 0;
    logic [63:0] prev = '0;
    logic [63:0] cur;
    build(n, m, s);
    set_cfg(n, m, s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start"}, {61'd0, aif.addr_valid, busy, done}, 64'b110);
    while (idx < exp_x.size() && cyc < 4000) begin
      cur = outs();
      if (hold) chk({tag, "_hold"}, cur, prev);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (mid_start && cyc == 6) begin
        start = 1'b1;
        set_cfg(7, 2, 1);
      end else begin
        start = 1'b0;
      end
      aif.addr_ready = rdy;
      if (rdy) begin
        chk({tag, "_pair"}, cur, {30'd0, 1'b1, exp_l[idx], 16'(exp_w[idx]), 16'(exp_x[idx])});
        idx++;
      end
      hold = !rdy;
      prev = cur;
      cyc++;
      @(negedge clk);
      if (abort_at > 0 && idx == abort_at) break;
    end
    aif.addr_ready = 1'b0;
    start = 1'b0;
    checks++;
    assert (cyc < 4000) else begin
      errors++;
      $error("FAIL %s_timeout: got=%0d handshakes expected=%0d", tag, idx, exp_x.size());
    end
    if (abort_at > 0) begin
      reset = 1'b1;
      @(negedge clk);
      chk({tag, "_reset_outs"}, {outs(), busy, done, err}, '0);
      reset = 1'b0;
      repeat (6) begin
        @(negedge clk);
        chk({tag, "_no_done"}, {61'd0, done, busy, aif.addr_valid}, '0);
      end
    end else begin
      chk({tag, "_done"}, {61'd0, done, busy, aif.addr_valid}, 64'b100);
      @(negedge clk);
      chk({tag, "_idle"}, {61'd0, done, busy, aif.addr_valid}, '0);
    end
  endtask

  task automatic illegal(input string tag, input int n, input int m, input int s);
    set_cfg(n, m, s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"}, {61'd0, err, busy, aif.addr_valid}, 64'b100);
    @(negedge clk);
    chk({tag, "_after"}, {61'd0, err, busy, aif.addr_valid}, '0);
  endtask

  initial begin
    int n, m, s;
    aif.addr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {outs(), busy, done, err}, '0);
    reset = 1'b0;
    @(negedge clk);
    run_pass("basic", 4, 3, 1, 0, 0, 0);
    run_pass("backpressure", 4, 3, 1, 1, 0, 0);
    illegal("m_gt_n", 4, 5, 1);
    illegal("m_zero", 4, 0, 1);
    run_pass("abort", 4, 3, 1, 0, 10, 0);
    run_pass("replay", 4, 3, 1, 0, 0, 0);
    run_pass("one", 1, 1, 1, 0, 0, 0);
    run_pass("m_eq_n", 3, 3, 1, 2, 0, 0);
    run_pass("start_in_run", 5, 2, 1, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 7);
      m = $urandom_range(1, n);
      run_pass("rand", n, m, 1, 2, 0, 0);
    end
`ifdef CONV_SEQ_STRIDE_EN
    run_pass("stride2", 5, 3, 2, 0, 0, 0);
    illegal("stride0", 5, 3, 0);
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 8);
      m = $urandom_range(1, n);
      s = $urandom_range(1, 3);
      run_pass("rand_stride", n, m, s, 2, 0, 0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
